// File: rtl/npu_mem_pkg.sv
// Shared memory-subsystem types: arbiter FSM states and default bus widths.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/sdram_read_arbiter_if.sv
// Requester-side and SDRAM-side read channel bundle; the arbiter is the slave,
// the requesters plus the SDRAM read wrapper form the master side.
interface sdram_read_arbiter_if
    import npu_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic                           rsp_last;
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic [ADDR_W-1:0]              mem_req_addr;
    logic [LEN_W-1:0]               mem_req_len;
    logic                           mem_rsp_valid;
    logic [DATA_W-1:0]              mem_rsp_data;
    logic                           err_spurious;

    modport slave (
        input  req_valid, req_addr, req_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_last,
               mem_req_valid, mem_req_addr, mem_req_len, err_spurious
    );

    modport master (
        output req_valid, req_addr, req_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
               mem_req_valid, mem_req_addr, mem_req_len, err_spurious
    );
endinterface

// File: rtl/sdram_read_arbiter_rr_pick.sv
// Combinational masked-priority picker: first set request at or after ptr wins.
module rr_pick #(
    parameter int  N     = 3,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM read channel among NUM_REQ burst requesters.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module sdram_read_arbiter
    import npu_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input logic               clk,
    input logic               rst_n,
    sdram_read_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [LEN_W-1:0]   beat_cnt;
    logic [NUM_REQ-1:0] grant;
    logic               any;

    logic [ADDR_W-1:0]  cmd_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_vld;
    logic [NUM_REQ-1:0] vld_p1;
    logic [DATA_W-1:0]  rsp_data_p1;
    logic               rsp_last_p1;
    logic               err_q;

    // In fixed-priority mode rr_ptr never leaves 0, so the picker degrades to lowest-index-wins.
    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif

    // Grant is gated by rst_n so every output reads 0 while reset is held.
    assign bus.req_ready     = (state == IDLE && rst_n) ? grant : '0;
    assign bus.mem_req_valid = cmd_vld;
    assign bus.mem_req_addr  = cmd_addr;
    assign bus.mem_req_len   = cmd_len;
    assign bus.rsp_valid     = vld_p1;
    assign bus.rsp_data      = rsp_data_p1;
    assign bus.rsp_last      = rsp_last_p1;
    assign bus.err_spurious  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            beat_cnt    <= '0;
            cmd_vld     <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            vld_p1      <= '0;
            rsp_data_p1 <= '0;
            rsp_last_p1 <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_p1      <= '0;
            rsp_last_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_rsp_valid) err_q <= 1'b1;
                    if (any) begin
                        owner    <= win_idx;
                        cmd_addr <= bus.req_addr[win_idx];
                        cmd_len  <= bus.req_len[win_idx];
                        beat_cnt <= bus.req_len[win_idx];
                        rr_ptr   <= next_ptr;
                        cmd_vld  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_rsp_valid) err_q <= 1'b1;
                    if (bus.mem_req_ready) begin
                        cmd_vld <= 1'b0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    // p1: returned beat registered and steered to the burst owner
                    if (bus.mem_rsp_valid) begin
                        vld_p1      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                        rsp_data_p1 <= bus.mem_rsp_data;
                        rsp_last_p1 <= (beat_cnt == '0);
                        if (beat_cnt == '0) state <= IDLE;
                        else                beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Table-driven burst bench with a beat scoreboard for sdram_read_arbiter.
module tb_sdram_read_arbiter;
    typedef struct {
        logic [2:0]  rv;
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [2:0] mask;
        logic [7:0] len;
        int         stall;
        int         owner;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   tag = 0;
    exp_t sbq[$];
    vec_t vecs[8];

    sdram_read_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    sdram_read_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every forwarded beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid != 3'b000) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", {61'd0, bus.rsp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_valid", {61'd0, bus.rsp_valid}, {61'd0, e.rv});
                chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, e.data});
                chk("rsp_last", {63'd0, bus.rsp_last}, {63'd0, e.last});
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge in the following IDLE cycle.
    task automatic run_burst(input logic [2:0] mask, input logic [7:0] len, input int stall,
                             input int owner, input int abort_at);
        logic [2:0]  g;
        logic [2:0]  exp_g;
        logic [31:0] a;
        logic [31:0] d;
        int          n;
        exp_g = 3'b001 << owner;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[i] = 32'h100 + (32'(i) << 12) + (32'(tag) << 4);
            bus.req_len[i]  = len;
        end
        tag++;
        bus.req_valid = mask;
        #1;
        n = 0;
        while (bus.req_ready == 3'b000 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        g = bus.req_ready;
        chk("grant", {61'd0, g}, {61'd0, exp_g});
        chk("grant_turnaround", 64'(n), 64'd0);
        if (g == 3'b000) begin
            bus.req_valid = 3'b000;
            return;
        end
        a = 32'h100 + (32'(owner) << 12) + (32'(tag - 1) << 4);
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            bus.req_valid = mask & ~exp_g;
            chk("cmd_valid", {63'd0, bus.mem_req_valid}, 64'd1);
            chk("cmd_addr", {32'd0, bus.mem_req_addr}, {32'd0, a});
            chk("cmd_len", {56'd0, bus.mem_req_len}, {56'd0, len});
            bus.mem_req_ready = (c == stall);
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        chk("cmd_drop", {63'd0, bus.mem_req_valid}, 64'd0);
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) break;
            d = $urandom;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = d;
            sbq.push_back('{exp_g, d, (b == int'(len))});
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        bus.req_valid     = 3'b000;
    endtask

    initial begin
        int n;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        vecs[0] = '{3'b111, 8'd0, 0, 0};
        vecs[1] = '{3'b111, 8'd1, 0, 0};
        vecs[2] = '{3'b111, 8'd2, 0, 0};
        vecs[3] = '{3'b111, 8'd3, 0, 0};
        vecs[4] = '{3'b001, 8'd3, 0, 0};
        vecs[5] = '{3'b010, 8'd2, 5, 1};
        vecs[6] = '{3'b101, 8'd1, 1, 0};
        vecs[7] = '{3'b110, 8'd0, 0, 1};
`else
        vecs[0] = '{3'b111, 8'd0, 0, 0};
        vecs[1] = '{3'b111, 8'd1, 0, 1};
        vecs[2] = '{3'b111, 8'd2, 0, 2};
        vecs[3] = '{3'b111, 8'd3, 0, 0};
        vecs[4] = '{3'b001, 8'd3, 0, 0};
        vecs[5] = '{3'b010, 8'd2, 5, 1};
        vecs[6] = '{3'b101, 8'd1, 1, 2};
        vecs[7] = '{3'b110, 8'd0, 0, 1};
`endif
        bus.req_valid     = 3'b111;
        bus.req_addr      = '0;
        bus.req_len       = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", {61'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {61'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
        chk("rst_rsp_last", {63'd0, bus.rsp_last}, 64'd0);
        chk("rst_cmd_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        chk("rst_cmd_addr", {32'd0, bus.mem_req_addr}, 64'd0);
        chk("rst_cmd_len", {56'd0, bus.mem_req_len}, 64'd0);
        chk("rst_err", {63'd0, bus.err_spurious}, 64'd0);
        bus.req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            run_burst(vecs[k].mask, vecs[k].len, vecs[k].stall, vecs[k].owner, -1);
        end
        chk("err_clean", {63'd0, bus.err_spurious}, 64'd0);

        // Beat with no open burst.
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk("err_spurious_set", {63'd0, bus.err_spurious}, 64'd1);
        run_burst(3'b010, 8'd2, 0, 1, -1);
        chk("err_spurious_sticky", {63'd0, bus.err_spurious}, 64'd1);

        run_burst(3'b100, 8'hFF, 0, 2, -1);
        chk("err_after_maxlen", {63'd0, bus.err_spurious}, 64'd1);

        // Abort an 8-beat burst after two beats.
        run_burst(3'b001, 8'd7, 0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", {61'd0, bus.req_ready}, 64'd0);
        chk("abort_rsp_valid", {61'd0, bus.rsp_valid}, 64'd0);
        chk("abort_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
        chk("abort_rsp_last", {63'd0, bus.rsp_last}, 64'd0);
        chk("abort_cmd_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        chk("abort_err", {63'd0, bus.err_spurious}, 64'd0);
        chk("abort_sb_empty", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk("abort_leftover_err", {63'd0, bus.err_spurious}, 64'd1);
        run_burst(3'b001, 8'd1, 0, 0, -1);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Shares the single SDRAM read channel among `NUM_REQ` burst requesters (CPU instruction fetch, weight loader, activation loader). The block grants one requester at a time with round-robin fairness, issues that requester's burst command downstream, and steers the returned data beats back to the owner. It sits between the requesters and the SDRAM read wrapper, inside the top level.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8).
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: beat width.
- `LEN_W`, default 8: burst length field; it encodes beats−1, so one burst is 1..2^LEN_W beats.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in [NUM_REQ]: request pending; held, together with its addr and len, until `req_ready`.
- `req_addr` in [NUM_REQ][ADDR_W]: burst start address.
- `req_len` in [NUM_REQ][LEN_W]: beats−1.
- `req_ready` out [NUM_REQ]: one-hot grant pulse; the request is accepted in this cycle.
- `rsp_valid` out [NUM_REQ]: one-hot, beat valid for the owner.
- `rsp_data` out DATA_W: beat data, shared by all requesters.
- `rsp_last` out 1: final beat of the burst, qualified by `rsp_valid`.
- `mem_req_valid` out 1: downstream command valid.
- `mem_req_ready` in 1: downstream command accepted.
- `mem_req_addr` out ADDR_W: command address.
- `mem_req_len` out LEN_W: command length (beats−1).
- `mem_rsp_valid` in 1: downstream beat valid; downstream has no backpressure.
- `mem_rsp_data` in DATA_W: downstream beat.
- `err_spurious` out 1: sticky flag, set by a beat arriving with no open burst.

## Operation
- The FSM has three states: IDLE, ISSUE and STREAM.
- **IDLE**
  - If any `req_valid` is high, the round-robin picker selects a winner, starting the search at `rr_ptr`.
  - `req_ready[winner]` pulses combinationally in this cycle.
  - The block latches owner, addr and len, and loads `beat_cnt` with len.
  - `rr_ptr` becomes (winner+1) mod NUM_REQ, and the FSM goes to ISSUE.
  - If no `req_valid` is high, the FSM stays in IDLE.
- **ISSUE**
  - `mem_req_valid`=1, with the latched addr and len.
  - When `mem_req_ready`=1, the FSM goes to STREAM.
  - The command stays stable while `mem_req_ready` is low.
- **STREAM**
  - Each `mem_rsp_valid` produces a registered beat: `rsp_valid[owner]`, `rsp_data`, and `rsp_last` when `beat_cnt`==0.
  - `beat_cnt` decrements on each beat.
  - On the beat where `beat_cnt`==0, the FSM goes to IDLE.
- **Beat outside STREAM** (in IDLE or ISSUE): the beat is dropped, no `rsp_valid` is produced, and `err_spurious` is set. `err_spurious` clears only on reset.
- **Simultaneous requests**: exactly one requester is granted per IDLE visit; the others keep `req_valid` asserted.
- **Request withdrawal**: dropping `req_valid` before `req_ready` is legal and is not a grant.
- **Wrap-around**: `rr_ptr` wraps from NUM_REQ−1 to 0. The address is passed through unchanged; the wrapper handles SDRAM row crossing.
- **Reset mid-burst**: the FSM returns to IDLE, and all outputs go to 0. Beats still arriving from the aborted burst set `err_spurious`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `mem_req_valid`=0, `mem_req_addr`=0, `mem_req_len`=0, `err_spurious`=0, `rr_ptr`=0, state IDLE.
- Grant to command: grant in cycle T, `mem_req_valid` high from T+1.
- Beat latency: a beat at `mem_rsp_valid` in cycle B appears on `rsp_*` in B+1.
- Burst-to-burst turnaround: after the last beat, one IDLE cycle, then the next grant. Minimum command spacing is therefore the burst beats plus 2 cycles.
- `req_ready` is a combinational function of state, `req_valid` and `rr_ptr`. All other outputs are registered.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins. `rr_ptr` is unused and held at 0.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `npu_mem_pkg`:
  - `arb_state_e` (IDLE, ISSUE, STREAM)
  - default `ADDR_W`, `DATA_W` and `LEN_W` localparams
- One sub-module, `rr_pick`: combinational masked-priority picker.
  - Inputs: request vector, start pointer.
  - Outputs: one-hot grant, any-valid.
  - Reused by both the round-robin and the fixed-priority modes (fixed priority passes pointer 0).

## Test plan
- **Single request**: req0 addr=0x100, len=3 -> `req_ready[0]` at T, `mem_req_valid` at T+1. Four beats return, giving four `rsp_valid[0]`, with `rsp_last` on the 4th only.
- **Three simultaneous requests, held**: `req_valid`=3'b111 held -> grants in order 0,1,2,0. With the macro defined, grants are 0,0,0.
- **Command backpressure**: `mem_req_ready` low for 5 cycles -> `mem_req_valid`, addr and len stable for all 6 cycles, and no beat is forwarded until acceptance.
- **Spurious beat**: `mem_rsp_valid` pulse in IDLE -> no `rsp_valid`, and `err_spurious` is 1 and stays 1 through later bursts.
- **Reset mid-STREAM**: `rst_n` low after 2 of 8 beats -> all outputs 0 immediately. A remaining beat after reset sets `err_spurious`, and the next request is granted normally.
- **Maximum length**: len=8'hFF -> exactly 256 beats, `rsp_last` on beat 256, and `beat_cnt` does not underflow.
